branch_predictor: RTL and testbench

//  gshare direction predictor feeding the fetch-stage branch classifier's 1-bit prediction input.

---
 rtl/branch_predictor_pkg.sv | 33 +++
 rtl/branch_predictor_pht_ram.sv | 30 +++
 rtl/branch_predictor.sv | 122 ++++++++++++
 tb/tb_branch_predictor.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types for the gshare branch predictor.
//   ctr_e      : 2-bit saturating counter encodings
//   state_e    : sweep/run FSM states
//   ctr_next() : saturating counter update used on the write-back path
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    CntSnt = 2'd0,
    CntWnt = 2'd1,
    CntWt  = 2'd2,
    CntSt  = 2'd3
  } ctr_e;

  // Weakly not-taken: the first taken outcome flips an entry to predict taken.
  localparam logic [1:0] InitCntDefault = 2'd1;

  typedef enum logic {
    StInit,
    StRun
  } state_e;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr != 2'(CntSt)) res = ctr + 2'd1;
    end else begin
      if (ctr != 2'(CntSnt)) res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_predictor_pht_ram.sv
// Pattern history table: 2**IdxW x 2-bit distributed RAM.
//   clk_i              : write clock
//   a_addr_i/a_rdata_o : asynchronous read port (lookup)
//   b_addr_i/b_rdata_o : asynchronous read port sharing the write address
//   b_we_i/b_wdata_i   : synchronous write port (update / init sweep)
// No reset: contents are defined by the init sweep in the parent.
module branch_predictor_pht_ram #(
  parameter int unsigned IdxW = 8
) (
  input  logic            clk_i,
  input  logic [IdxW-1:0] a_addr_i,
  output logic [1:0]      a_rdata_o,
  input  logic [IdxW-1:0] b_addr_i,
  output logic [1:0]      b_rdata_o,
  input  logic            b_we_i,
  input  logic [1:0]      b_wdata_i
);

  localparam int unsigned Depth = 2 ** IdxW;

  logic [1:0] mem [Depth];

  assign a_rdata_o = mem[a_addr_i];
  assign b_rdata_o = mem[b_addr_i];

  always_ff @(posedge clk_i) begin
    if (b_we_i) mem[b_addr_i] <= b_wdata_i;
  end

endmodule

// File: rtl/branch_predictor.sv
// gshare direction predictor.
//   clk, rstn                  : clock, synchronous active-low reset
//   lk_en/lk_stall/lk_pc       : fetch lookup request
//   pred_taken/pred_hist       : combinational prediction and the GHR it used
//   ready                      : high once the PHT init sweep has completed
//   up_en/up_pc/up_hist/up_taken/up_mispred : execute write-back
//   cnt_upd/cnt_miss           : saturating resolved-branch / misprediction counts
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned IDX_W    = 8,
  parameter int unsigned HIST_W   = 8,
  parameter int unsigned PC_W     = 32,
  parameter logic [1:0]  INIT_CNT = InitCntDefault
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              lk_en,
  input  logic              lk_stall,
  input  logic [PC_W-1:0]   lk_pc,
  output logic              pred_taken,
  output logic [HIST_W-1:0] pred_hist,
  output logic              ready,
  input  logic              up_en,
  input  logic [PC_W-1:0]   up_pc,
  input  logic [HIST_W-1:0] up_hist,
  input  logic              up_taken,
  input  logic              up_mispred,
  output logic [31:0]       cnt_upd,
  output logic [31:0]       cnt_miss
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  init_idx_q, init_idx_d;
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [31:0]       cnt_upd_q, cnt_upd_d;
  logic [31:0]       cnt_miss_q, cnt_miss_d;

  logic [IDX_W-1:0] lk_idx, up_idx, pht_b_addr;
  logic [1:0]       pht_a_rdata, pht_b_rdata, pht_wdata;
  logic             pht_we, in_init, in_run, upd_fire, miss_fire;

  // Only the low PC bits form the index.
  logic unused_pc;
  assign unused_pc = ^{lk_pc[PC_W-1:IDX_W], up_pc[PC_W-1:IDX_W]};

  assign in_init   = (state_q == StInit);
  assign in_run    = (state_q == StRun);
  assign upd_fire  = in_run && up_en;
  assign miss_fire = upd_fire && up_mispred;

  assign lk_idx = lk_pc[IDX_W-1:0] ^ IDX_W'(ghr_q);
  assign up_idx = up_pc[IDX_W-1:0] ^ IDX_W'(up_hist);

  // Port B is owned by the sweep during init, by write-back afterwards.
  assign pht_b_addr = in_init ? init_idx_q : up_idx;
  assign pht_wdata  = in_init ? INIT_CNT : ctr_next(pht_b_rdata, up_taken);
  assign pht_we     = rstn && (in_init || upd_fire);

  branch_predictor_pht_ram #(
    .IdxW (IDX_W)
  ) u_pht (
    .clk_i     (clk),
    .a_addr_i  (lk_idx),
    .a_rdata_o (pht_a_rdata),
    .b_addr_i  (pht_b_addr),
    .b_rdata_o (pht_b_rdata),
    .b_we_i    (pht_we),
    .b_wdata_i (pht_wdata)
  );

  assign ready      = in_run;
  assign pred_taken = in_run && pht_a_rdata[1];
  assign pred_hist  = in_run ? ghr_q : '0;
  assign cnt_upd    = cnt_upd_q;
  assign cnt_miss   = cnt_miss_q;

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    ghr_d      = ghr_q;
    unique case (state_q)
      StInit: begin
        init_idx_d = init_idx_q + IDX_W'(1);
        if (init_idx_q == '1) state_d = StRun;
      end
      StRun: begin
        // Repair wins: the same-cycle lookup is on a squashed path.
        if (miss_fire) begin
          ghr_d = {up_hist[HIST_W-2:0], up_taken};
        end else if (lk_en && !lk_stall) begin
          ghr_d = {ghr_q[HIST_W-2:0], pred_taken};
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    cnt_upd_d  = cnt_upd_q;
    cnt_miss_d = cnt_miss_q;
    if (upd_fire && (cnt_upd_q != '1))   cnt_upd_d  = cnt_upd_q + 32'd1;
    if (miss_fire && (cnt_miss_q != '1)) cnt_miss_d = cnt_miss_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StInit;
      init_idx_q <= '0;
      ghr_q      <= '0;
      cnt_upd_q  <= '0;
      cnt_miss_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      ghr_q      <= ghr_d;
      cnt_upd_q  <= cnt_upd_d;
      cnt_miss_q <= cnt_miss_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (IDX_W = HIST_W = 4).
module tb_branch_predictor;

  localparam int Ent = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        lk_en, lk_stall;
  logic [31:0] lk_pc;
  logic        pred_taken;
  logic [3:0]  pred_hist;
  logic        ready;
  logic        up_en;
  logic [31:0] up_pc;
  logic [3:0]  up_hist;
  logic        up_taken, up_mispred;
  logic [31:0] cnt_upd, cnt_miss;

  always #5 clk = ~clk;

  branch_predictor #(
    .IDX_W    (4),
    .HIST_W   (4),
    .PC_W     (32),
    .INIT_CNT (2'b01)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .lk_en      (lk_en),
    .lk_stall   (lk_stall),
    .lk_pc      (lk_pc),
    .pred_taken (pred_taken),
    .pred_hist  (pred_hist),
    .ready      (ready),
    .up_en      (up_en),
    .up_pc      (up_pc),
    .up_hist    (up_hist),
    .up_taken   (up_taken),
    .up_mispred (up_mispred),
    .cnt_upd    (cnt_upd),
    .cnt_miss   (cnt_miss)
  );

  // Reference model: counters as plain integers, history as an integer shift register.
  int     m_pht [Ent];
  int     m_ghr;
  int     m_sweep;
  bit     m_ready;
  longint m_upd, m_miss;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int model_pred();
    int idx;
    idx = int'(lk_pc % 32'd16) ^ m_ghr;
    return (m_ready && m_pht[idx] >= 2) ? 1 : 0;
  endfunction

  // Check outputs mid-low-phase, advance the model, then cross one posedge.
  task automatic tick();
    int pred, idx;
    #1;
    pred = model_pred();
    chk("ready", 32'(ready), 32'(m_ready));
    chk("pred_taken", 32'(pred_taken), 32'(pred));
    chk("pred_hist", 32'(pred_hist), m_ready ? 32'(m_ghr) : 32'd0);
    chk("cnt_upd", cnt_upd, 32'(m_upd));
    chk("cnt_miss", cnt_miss, 32'(m_miss));
    if (!rstn) begin
      m_sweep = Ent;
      m_ready = 1'b0;
      m_ghr   = 0;
      m_upd   = 0;
      m_miss  = 0;
    end else if (!m_ready) begin
      m_sweep--;
      if (m_sweep == 0) begin
        for (int i = 0; i < Ent; i++) m_pht[i] = 1;
        m_ready = 1'b1;
      end
    end else begin
      if (up_en) begin
        idx = int'(up_pc % 32'd16) ^ int'(up_hist);
        if (up_taken) m_pht[idx] = (m_pht[idx] == 3) ? 3 : m_pht[idx] + 1;
        else          m_pht[idx] = (m_pht[idx] == 0) ? 0 : m_pht[idx] - 1;
        if (m_upd < 64'hFFFF_FFFF) m_upd++;
        if (up_mispred && m_miss < 64'hFFFF_FFFF) m_miss++;
      end
      if (up_en && up_mispred)    m_ghr = ((int'(up_hist) * 2) + int'(up_taken)) % 16;
      else if (lk_en && !lk_stall) m_ghr = ((m_ghr * 2) + pred) % 16;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    lk_en = 0; lk_stall = 0; lk_pc = 0;
    up_en = 0; up_pc = 0; up_hist = 0; up_taken = 0; up_mispred = 0;
  endtask

  task automatic rand_inputs();
    lk_en      = 1'($urandom);
    lk_stall   = ($urandom_range(0, 3) == 0);
    lk_pc      = $urandom;
    up_en      = 1'($urandom);
    up_pc      = $urandom;
    up_hist    = 4'($urandom);
    up_taken   = 1'($urandom);
    up_mispred = ($urandom_range(0, 2) == 0);
  endtask

  task automatic check_all_init(input string tag);
    for (int i = 0; i < Ent; i++) chk(tag, 32'(dut.u_pht.mem[i]), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < Ent; i++) m_pht[i] = 0;
    rstn = 0;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    m_sweep = Ent; m_ready = 0; m_ghr = 0; m_upd = 0; m_miss = 0;
    tick();

    // Sweep: ready low for exactly 16 cycles, inputs ignored meanwhile.
    rstn = 1;
    for (int i = 0; i < Ent; i++) begin
      rand_inputs();
      tick();
    end
    idle_inputs();
    chk("ready_after_sweep", 32'(ready), 32'd1);
    check_all_init("pht_init");
    for (int i = 0; i < Ent; i++) begin
      lk_pc = 32'(i);
      tick();
    end

    // Four taken updates to index 5: counter 2,3,3,3.
    lk_pc = 5; up_en = 1; up_pc = 5; up_hist = 0; up_taken = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ctr5", 32'(dut.u_pht.mem[5]), (i == 0) ? 32'd2 : 32'd3);
    end
    up_en = 0;
    chk("pred_after_train", 32'(pred_taken), 32'd1);

    // Four taken-predicting lookups, keeping the index pinned on entry 5.
    lk_en = 1;
    for (int i = 0; i < 4; i++) begin
      lk_pc = 32'(5 ^ m_ghr);
      tick();
    end
    chk("ghr_ones", 32'(pred_hist), 32'hF);

    lk_stall = 1;
    for (int i = 0; i < 3; i++) tick();
    chk("ghr_stall", 32'(pred_hist), 32'hF);
    lk_stall = 0;

    // Misprediction repair overrides a concurrent lookup.
    lk_en = 1; lk_pc = 0;
    up_en = 1; up_mispred = 1; up_hist = 4'b0011; up_taken = 0; up_pc = 9;
    tick();
    idle_inputs();
    chk("ghr_repair", 32'(pred_hist), 32'h6);
    chk("miss_one", cnt_miss, 32'd1);

    // Same-cycle lookup and update to index 3: no bypass.
    lk_pc = 32'(3 ^ 6);
    up_en = 1; up_pc = 3; up_hist = 0; up_taken = 1;
    #1;
    chk("same_cycle_old", 32'(pred_taken), 32'd0);
    tick();
    up_en = 0;
    #1;
    chk("same_cycle_new", 32'(pred_taken), 32'd1);
    tick();

    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      tick();
    end

    // One-cycle reset mid-run restarts everything.
    idle_inputs();
    rstn = 0;
    tick();
    rstn = 1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_hist", 32'(pred_hist), 32'd0);
    chk("rst_cnt_upd", cnt_upd, 32'd0);
    chk("rst_ghr", 32'(dut.ghr_q), 32'd0);
    for (int i = 0; i < Ent; i++) begin
      rand_inputs();
      tick();
    end
    idle_inputs();
    chk("ready_after_resweep", 32'(ready), 32'd1);
    check_all_init("pht_reinit");
    for (int i = 0; i < 50; i++) begin
      rand_inputs();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
